// File: rtl/spoly_prng.sv
// Seeded xorshift32 rejection sampler producing {sign, index} samples in [0,P) for the spoly generator.
// Optional saturating reject counter output enabled by defining SPOLY_PRNG_REJCNT_EN.
module spoly_prng #(
  parameter int unsigned P            = 677,
  parameter int unsigned IDX_W        = 10,
  parameter int unsigned OUT_W        = 13,
  parameter logic [31:0] SEED_DEFAULT = 32'd136987453
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [31:0]      seed_i,
  input  logic             req,
  input  logic             rand_ready,
  output logic             rand_valid,
  output logic [OUT_W-1:0] rand_o,
`ifdef SPOLY_PRNG_REJCNT_EN
  output logic [15:0]      rej_cnt,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        x_q, x_d;
  logic               valid_q, valid_d;
  logic [OUT_W-1:0]   rand_q, rand_d;
  logic [31:0]        xn;
  logic [31:0]        cand;
  logic               accept;
`ifdef SPOLY_PRNG_REJCNT_EN
  logic [15:0]        rej_q, rej_d;
`endif

  function automatic logic [31:0] xs_step(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  always_comb begin
    xn      = xs_step(x_q);
    cand    = 32'(xn[IDX_W-1:0]);
    accept  = (cand < P);
    state_d = state_q;
    x_d     = x_q;
    valid_d = valid_q;
    rand_d  = rand_q;
`ifdef SPOLY_PRNG_REJCNT_EN
    rej_d   = rej_q;
`endif
    // seed_load overrides everything, including a handshake in the same cycle
    if (seed_load) begin
      x_d     = (seed_i == 32'd0) ? SEED_DEFAULT : seed_i;
      state_d = ST_IDLE;
      valid_d = 1'b0;
`ifdef SPOLY_PRNG_REJCNT_EN
      rej_d   = '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req) state_d = ST_GEN;
        end
        ST_GEN: begin
          x_d = xn;
          if (accept) begin
            rand_d          = '0;
            rand_d[IDX_W:0] = xn[IDX_W:0];
            valid_d         = 1'b1;
            state_d         = ST_HOLD;
          end else begin
`ifdef SPOLY_PRNG_REJCNT_EN
            if (rej_q != 16'hFFFF) rej_d = rej_q + 16'd1;
`endif
          end
        end
        ST_HOLD: begin
          if (rand_ready) begin
            valid_d = 1'b0;
            state_d = req ? ST_GEN : ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= SEED_DEFAULT;
      valid_q <= 1'b0;
      rand_q  <= '0;
`ifdef SPOLY_PRNG_REJCNT_EN
      rej_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      rand_q  <= rand_d;
`ifdef SPOLY_PRNG_REJCNT_EN
      rej_q   <= rej_d;
`endif
    end
  end

  assign rand_valid = valid_q;
  assign rand_o     = rand_q;
  assign busy       = (state_q == ST_GEN);
`ifdef SPOLY_PRNG_REJCNT_EN
  assign rej_cnt    = rej_q;
`endif

endmodule

// File: tb/tb_spoly_prng.sv
// Self-checking bench for spoly_prng: hand-computed vector table plus model-driven sample streams.
// Also checks rej_cnt when built with SPOLY_PRNG_REJCNT_EN.
module tb_spoly_prng;

  localparam logic [31:0] SEED_DEF = 32'd136987453;

  logic        clk;
  logic        rst_n;
  logic        seed_load;
  logic [31:0] seed_i;
  logic        req;
  logic        rand_ready;
  logic        rand_valid;
  logic [12:0] rand_o;
  logic        busy;
`ifdef SPOLY_PRNG_REJCNT_EN
  logic [15:0] rej_cnt;
`endif

  int total = 0;
  int bad   = 0;

  logic [31:0] mx;
  logic [15:0] mrej;
  logic [12:0] last_o;

  spoly_prng #(
    .P(677), .IDX_W(10), .OUT_W(13), .SEED_DEFAULT(SEED_DEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed_i     (seed_i),
    .req        (req),
    .rand_ready (rand_ready),
    .rand_valid (rand_valid),
    .rand_o     (rand_o),
`ifdef SPOLY_PRNG_REJCNT_EN
    .rej_cnt    (rej_cnt),
`endif
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [31:0] seed;
    logic        rq;
    logic        rdy;
    logic        ev;
    logic [12:0] eo;
    logic        eb;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] t;
    t = x ^ (x << 13);
    t = t ^ (t >> 17);
    t = t ^ (t << 5);
    return t;
  endfunction

  task automatic model_next(output logic [12:0] o, output int rej);
    rej = 0;
    mx  = xs(mx);
    while (mx[9:0] >= 10'd677) begin
      rej++;
      if (mrej != 16'hFFFF) mrej = mrej + 16'd1;
      mx = xs(mx);
    end
    o = 13'(mx[10:0]);
  endtask

  // Expects req=1, rand_ready=1; starts at a negedge in IDLE or with a valid sample showing.
  task automatic stream(input int n);
    logic [12:0] eo;
    int          er;
    int          cyc;
    for (int i = 0; i < n; i++) begin
      model_next(eo, er);
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!rand_valid && cyc < 300);
      chk("stream_valid", 32'(rand_valid), 32'd1);
      chk("stream_rand_o", 32'(rand_o), 32'(eo));
      chk("stream_latency", cyc, er + 2);
      chk("stream_idx_range", 32'(rand_o[9:0] < 10'd677), 32'd1);
`ifdef SPOLY_PRNG_REJCNT_EN
      chk("stream_rej_cnt", 32'(rej_cnt), 32'(mrej));
`endif
      last_o = eo;
    end
  endtask

  task automatic do_load(input logic [31:0] s);
    seed_load = 1'b1;
    seed_i    = s;
    @(negedge clk);
    seed_load = 1'b0;
    mx   = (s == 32'd0) ? SEED_DEF : s;
    mrej = '0;
    chk("load_valid", 32'(rand_valid), 32'd0);
    chk("load_busy", 32'(busy), 32'd0);
`ifdef SPOLY_PRNG_REJCNT_EN
    chk("load_rej_cnt", 32'(rej_cnt), 32'd0);
`endif
  endtask

  initial begin
    rst_n = 1'b0; seed_load = 1'b0; seed_i = '0; req = 1'b0; rand_ready = 1'b0;
    mx = SEED_DEF; mrej = '0; last_o = '0;

    // seed=1 sequence: xn=0x00042021 -> 33, xn=0x04080601 -> 1537
    tbl[0] = '{1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 13'd0,    1'b0};
    tbl[1] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 13'd0,    1'b1};
    tbl[2] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 13'd33,   1'b0};
    tbl[3] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 13'd0,    1'b1};
    tbl[4] = '{1'b0, 32'd0, 1'b1, 1'b1, 1'b1, 13'd1537, 1'b0};
    tbl[5] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 13'd1537, 1'b0};
    tbl[6] = '{1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 13'd0,    1'b0};
    tbl[7] = '{1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 13'd0,    1'b0};
    tbl[8] = '{1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 13'd0,    1'b0};

    repeat (2) @(negedge clk);
    chk("reset_valid", 32'(rand_valid), 32'd0);
    chk("reset_rand_o", 32'(rand_o), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
`ifdef SPOLY_PRNG_REJCNT_EN
    chk("reset_rej_cnt", 32'(rej_cnt), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // sequence straight out of reset (SEED_DEFAULT)
    req = 1'b1; rand_ready = 1'b1;
    stream(5);

    // table: seed_load from HOLD, then seed=1 samples and handshake corners
    for (int i = 0; i < 9; i++) begin
      seed_load = tbl[i].ld; seed_i = tbl[i].seed; req = tbl[i].rq; rand_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", i), 32'(rand_valid), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      if (tbl[i].ev) chk($sformatf("tbl%0d_rand_o", i), 32'(rand_o), 32'(tbl[i].eo));
    end
    seed_load = 1'b0;

    // zero seed reproduces the reset sequence
    mx = SEED_DEF; mrej = '0;
    req = 1'b1; rand_ready = 1'b1;
    stream(5);

    // stall in HOLD for 10 cycles
    rand_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rand_valid), 32'd1);
      chk("stall_rand_o", 32'(rand_o), 32'(last_o));
    end
    rand_ready = 1'b1;
    stream(3);

    // seed_load colliding with a handshake
    do_load(32'h1234_5678);
    req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_idle_valid", 32'(rand_valid), 32'd0);
      chk("abort_idle_busy", 32'(busy), 32'd0);
    end
    req = 1'b1;
    stream(5);

    // long run against the model
    do_load(32'hDEAD_BEEF);
    stream(10000);

    // async reset in the middle of HOLD
    rand_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(rand_valid), 32'd0);
    chk("async_rst_rand_o", 32'(rand_o), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mx = SEED_DEF; mrej = '0;
    rand_ready = 1'b1;
    stream(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
